// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_FRAME_LEN = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    EXT   = 2'd2
  } ps2_state_e;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module ps2_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame capture, byte FIFO and make/break/extended decode.
// Define PS2_RX_PARITY_CHECK_EN to reject frames with a bad odd-parity bit.
//
//   state | meaning
//   IDLE  | waiting for a make code or a prefix byte
//   BREAK | F0 seen; next byte is the released key
//   EXT   | E0 seen; next byte is an extended make code (or F0)
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int FRAME_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo,
  output logic [3:0] cnt_hi,
  output logic [3:0] cnt_lo,
  output logic       disp_blank,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overflow
);

  localparam int         TW       = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_LEN - 1);

  logic [2:0]    ps2c_q, ps2c_d;
  logic [1:0]    ps2d_q, ps2d_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    bits_q, bits_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          push_q, push_d;
  logic [7:0]    push_byte_q, push_byte_d;
  logic          frame_err_q, frame_err_d;
  logic          fall, sample, frame_ok;

  ps2_state_e    state_q, state_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          blank_q, blank_d;
  logic          key_valid_q, key_valid_d;
  logic          overflow_q, overflow_d;
  logic          is_make;

  logic [7:0]    fifo_rd_data;
  logic          fifo_full, fifo_empty, fifo_pop;

  assign fifo_pop = ~fifo_empty;

  // bits_q holds start, data[7:0], parity (LSB first); the stop bit is the live sample
  always_comb begin
    ps2c_d      = {ps2c_q[1:0], ps2_clk};
    ps2d_d      = {ps2d_q[0], ps2_data};
    fall        = ps2c_q[2] & ~ps2c_q[1];
    sample      = ps2d_q[1];
    bit_cnt_d   = bit_cnt_q;
    bits_d      = bits_q;
    tmr_d       = tmr_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    frame_err_d = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    frame_ok    = ~bits_q[0] & sample & (^bits_q[9:1]);
`else
    frame_ok    = ~bits_q[0] & sample;
`endif
    if (fall) begin
      tmr_d = TW'(FRAME_TIMEOUT);
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          push_d      = 1'b1;
          push_byte_d = bits_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bits_d    = {sample, bits_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TW'(1);
    end else if (bit_cnt_q != 4'd0) begin
      bit_cnt_d = 4'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    blank_d     = blank_q;
    key_valid_d = 1'b0;
    is_make     = 1'b0;
    overflow_d  = overflow_q | (push_q & fifo_full & ~fifo_pop);
    if (fifo_pop) begin
      case (state_q)
        IDLE: begin
          if (fifo_rd_data == PS2_BREAK)    state_d = BREAK;
          else if (fifo_rd_data == PS2_EXT) state_d = EXT;
          else                              is_make = 1'b1;
        end
        EXT: begin
          if (fifo_rd_data == PS2_BREAK) begin
            state_d = BREAK;
          end else begin
            is_make = 1'b1;
            state_d = IDLE;
          end
        end
        BREAK: begin
          if (fifo_rd_data == code_q) blank_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // a repeat of the key already shown is typematic and does not count
    if (is_make && (blank_q || fifo_rd_data != code_q)) begin
      code_d      = fifo_rd_data;
      blank_d     = 1'b0;
      cnt_d       = cnt_q + 8'd1;
      key_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2c_q      <= 3'b111;
      ps2d_q      <= 2'b11;
      bit_cnt_q   <= 4'd0;
      bits_q      <= '0;
      tmr_q       <= '0;
      push_q      <= 1'b0;
      push_byte_q <= 8'h00;
      frame_err_q <= 1'b0;
      state_q     <= IDLE;
      code_q      <= 8'h00;
      cnt_q       <= 8'h00;
      blank_q     <= 1'b1;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ps2c_q      <= ps2c_d;
      ps2d_q      <= ps2d_d;
      bit_cnt_q   <= bit_cnt_d;
      bits_q      <= bits_d;
      tmr_q       <= tmr_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      blank_q     <= blank_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push    (push_q),
    .pop     (fifo_pop),
    .wr_data (push_byte_q),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign code_hi    = code_q[7:4];
  assign code_lo    = code_q[3:0];
  assign cnt_hi     = cnt_q[7:4];
  assign cnt_lo     = cnt_q[3:0];
  assign disp_blank = blank_q;
  assign key_valid  = key_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx; key presses are checked against a queue of expected code/count pairs.
module tb_ps2_keyboard_rx;

  localparam int TIMEOUT = 100;
  localparam int HALF    = 3;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] code_hi, code_lo, cnt_hi, cnt_lo;
  logic       disp_blank, key_valid, frame_err, overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  int          kv_count = 0;
  int          fe_count = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_cnt = 8'h00;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_DEPTH    (8),
    .FRAME_TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_hi    (code_hi),
    .code_lo    (code_lo),
    .cnt_hi     (cnt_hi),
    .cnt_lo     (cnt_lo),
    .disp_blank (disp_blank),
    .key_valid  (key_valid),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (frame_err) fe_count++;
    if (key_valid) begin
      kv_count++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL kv_unexpected: observed code=%0h%0h expected no key press", code_hi, code_lo);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("kv_code", {code_hi, code_lo}, e[15:8]);
        chk("kv_cnt", {cnt_hi, cnt_lo}, e[7:0]);
      end
    end
  end

  task automatic expect_key(input logic [7:0] b);
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({b, exp_cnt});
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    repeat (10) @(posedge clk);
  endtask

  task automatic check_disp(input string tag, input logic [7:0] code, input logic [7:0] cnt,
                            input logic blank);
    @(negedge clk);
    chk({tag, "_code"}, {code_hi, code_lo}, code);
    chk({tag, "_cnt"}, {cnt_hi, cnt_lo}, cnt);
    chk({tag, "_blank"}, disp_blank, blank);
  endtask

  initial begin
    int         kv0, fe0;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    chk("rst_code", {code_hi, code_lo}, 8'h00);
    chk("rst_cnt", {cnt_hi, cnt_lo}, 8'h00);
    chk("rst_blank", disp_blank, 1'b1);
    chk("rst_kv", key_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    kv0 = kv_count;
    expect_key(8'h1C);
    send_byte(8'h1C);
    check_disp("make1c", 8'h1C, 8'h01, 1'b0);
    chk("make1c_pulses", kv_count - kv0, 1);

    kv0 = kv_count;
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    check_disp("repeat", 8'h1C, 8'h01, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_disp("break1c", 8'h1C, 8'h01, 1'b1);
    chk("repeat_pulses", kv_count - kv0, 0);

    expect_key(8'h75);
    send_byte(8'hE0);
    send_byte(8'h75);
    check_disp("ext75", 8'h75, 8'h02, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_disp("extbrk75", 8'h75, 8'h02, 1'b1);

    kv0 = kv_count;
    fe0 = fe_count;
`ifdef PS2_RX_PARITY_CHECK_EN
    send_byte(8'h1C, 1'b1);
    check_disp("badpar", 8'h75, 8'h02, 1'b1);
    chk("badpar_ferr", fe_count - fe0, 1);
`else
    expect_key(8'h1C);
    send_byte(8'h1C, 1'b1);
    check_disp("badpar", 8'h1C, 8'h03, 1'b0);
    chk("badpar_ferr", fe_count - fe0, 0);
`endif
    kv0 = kv_count;
    fe0 = fe_count;
    send_byte(8'h33, 1'b0, 1'b1);
    chk("badstop_ferr", fe_count - fe0, 1);
    chk("badstop_kv", kv_count - kv0, 0);

    fe0 = fe_count;
    send_bits(11'b000_0101_0110, 7);
    repeat (TIMEOUT + 30) @(posedge clk);
    expect_key(8'h4D);
    send_byte(8'h4D);
    check_disp("timeout", 8'h4D, exp_cnt, 1'b0);
    chk("timeout_ferr", fe_count - fe0, 0);

    kv0 = kv_count;
    force dut.fifo_pop = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'h21 + 8'(i);
      send_byte(b);
    end
    @(negedge clk);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_stall_kv", kv_count - kv0, 0);
    for (int i = 0; i < 8; i++) begin
      b = 8'h21 + 8'(i);
      expect_key(b);
    end
    release dut.fifo_pop;
    repeat (20) @(posedge clk);
    check_disp("ovf_drain", 8'h28, exp_cnt, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_sb", exp_q.size(), 0);

    for (int i = 0; i < 256; i++) begin
      if (exp_cnt == 8'h00) break;
      b = (i % 2 == 1) ? 8'h11 : 8'h10;
      expect_key(b);
      send_byte(b);
    end
    @(negedge clk);
    chk("wrap_cnt", {cnt_hi, cnt_lo}, 8'h00);
    chk("wrap_sb", exp_q.size(), 0);

    send_bits(11'b110_1010_1010, 5);
    @(posedge clk); #1 clrn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_code", {code_hi, code_lo}, 8'h00);
    chk("midrst_cnt", {cnt_hi, cnt_lo}, 8'h00);
    chk("midrst_blank", disp_blank, 1'b1);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_kv", key_valid, 1'b0);
    chk("midrst_ferr", frame_err, 1'b0);
    #1 clrn = 1'b1;
    exp_cnt = 8'h00;
    exp_q.delete();
    expect_key(8'h1C);
    send_byte(8'h1C);
    check_disp("postrst", 8'h1C, 8'h01, 1'b0);
    chk("final_sb", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
